// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// The master drives start and the operands. The slave returns status and the result.
interface nibble_serial_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder that computes a + b + cin one 4-bit nibble per clock, LSB nibble first.
// A 4-bit propagate/generate ripple slice feeds a registered inter-nibble carry.
// Operands are captured on an accepted start.
// sum/cout update only on the cycle that raises done.
module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nibble_serial_adder_if.slave  bus
);
   localparam int unsigned N    = WIDTH / 4;
   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  work_q;
   logic [WIDTH-1:0]  sum_q;
   logic [IDXW-1:0]   idx_q;
   logic              carry_q;
   logic              cout_q;
   logic              busy_q;
   logic              done_q;

   logic [3:0]        a_nib;
   logic [3:0]        b_nib;
   logic [3:0]        p;
   logic [3:0]        g;
   logic [3:0]        s;
   logic              c1, c2, c3, c4;
   logic [WIDTH-1:0]  work_d;
   logic              last_nib;

   // Nibble slice: select the current nibble, ripple the carry, and merge the result into the work word
   always_comb begin
      a_nib  = 4'(a_q >> {idx_q, 2'b00});
      b_nib  = 4'(b_q >> {idx_q, 2'b00});
      p      = a_nib ^ b_nib;
      g      = a_nib & b_nib;
      c1     = g[0] | (p[0] & carry_q);
      c2     = g[1] | (p[1] & c1);
      c3     = g[2] | (p[2] & c2);
      c4     = g[3] | (p[3] & c3);
      s      = p ^ {c3, c2, c1, carry_q};
      work_d = work_q;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx_q == IDXW'(i)) begin
            work_d[4*i +: 4] = s;
         end
      end
      last_nib = (idx_q == IDXW'(N - 1));
   end

   // Control FSM with registered status and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               work_q  <= work_d;
               carry_q <= c4;
               idx_q   <= idx_q + IDXW'(1);
               if (last_nib) begin
                  sum_q   <= work_d;
                  cout_q  <= c4;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder.
// The 16-bit instance runs directed vectors. The 32-bit instance runs random vectors.
module tb_nibble_serial_adder;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int unsigned cyc = 0;
   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   nibble_serial_adder_if #(.WIDTH(16)) if16 ();
   nibble_serial_adder_if #(.WIDTH(32)) if32 ();

   nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
   nibble_serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      int unsigned due;
      string       name;
   } exp_t;

   exp_t q16[$];
   exp_t q32[$];
   exp_t e16, e32;
   logic [15:0] last16  = '0;
   logic        lastc16 = 1'b0;
   logic [31:0] last32  = '0;
   logic        lastc32 = 1'b0;
   int unsigned brun16 = 0;
   int unsigned brun32 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // 16-bit monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (if16.done) begin
            check("busy16_low_on_done", 64'(if16.busy), 64'd0);
            check("busy16_len", 64'(brun16), 64'd4);
            brun16 = 0;
            if (q16.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done16: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
               e16 = q16.pop_front();
               check({e16.name, "_sum"}, 64'(if16.sum), 64'(e16.sum[15:0]));
               check({e16.name, "_cout"}, 64'(if16.cout), 64'(e16.cout));
               check({e16.name, "_latency"}, 64'(cyc), 64'(e16.due));
               last16  = e16.sum[15:0];
               lastc16 = e16.cout;
            end
         end else begin
            check("sum16_stable", 64'({if16.cout, if16.sum}), 64'({lastc16, last16}));
            if (if16.busy) brun16++;
            else brun16 = 0;
         end
      end
   end

   // 32-bit monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (if32.done) begin
            check("busy32_len", 64'(brun32), 64'd8);
            brun32 = 0;
            if (q32.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done32: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
               e32 = q32.pop_front();
               check({e32.name, "_sum_cout"}, 64'({if32.cout, if32.sum}), 64'({e32.cout, e32.sum}));
               check({e32.name, "_latency"}, 64'(cyc), 64'(e32.due));
               last32  = e32.sum;
               lastc32 = e32.cout;
            end
         end else begin
            check("sum32_stable", 64'({if32.cout, if32.sum}), 64'({lastc32, last32}));
            if (if32.busy) brun32++;
            else brun32 = 0;
         end
      end
   end

   // Issue one op on the 16-bit DUT. The caller is at a negedge.
   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] xsum, input logic xcout, input bit keep,
                          input string name);
      int unsigned guard = 0;
      while (if16.busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_accept_timeout: got busy=1 expected busy=0 within 100 cycles", name);
      end
      if16.a     = a;
      if16.b     = b;
      if16.cin   = cin;
      if16.start = 1'b1;
      q16.push_back('{sum: {16'h0, xsum}, cout: xcout, due: cyc + 1 + 4, name: name});
      @(negedge clk);
      if (!keep) if16.start = 1'b0;
   endtask

   task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input bit keep);
      int unsigned guard = 0;
      logic [32:0] r;
      while (if32.busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL rand32_accept_timeout: got busy=1 expected busy=0 within 100 cycles");
      end
      r = 33'(a) + 33'(b) + 33'(cin);
      if32.a     = a;
      if32.b     = b;
      if32.cin   = cin;
      if32.start = 1'b1;
      q32.push_back('{sum: r[31:0], cout: r[32], due: cyc + 1 + 8, name: "rand32"});
      @(negedge clk);
      if (!keep) if32.start = 1'b0;
   endtask

   initial begin
      int unsigned guard;
      if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
      if32.start = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("reset_busy",  64'(if16.busy), 64'd0);
      check("reset_done",  64'(if16.done), 64'd0);
      check("reset_sum",   64'(if16.sum),  64'd0);
      check("reset_cout",  64'(if16.cout), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Carry ripples through every nibble
      issue16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, "t1_ffff_p1");
      repeat (6) @(negedge clk);
      issue16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0, "t2_1234");
      issue16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0, "t2_8000");
      issue16(16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1, 0, "t2_7fff_cin");

      // start while busy is ignored
      issue16(16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 1'b0, 0, "t3_busy_ignore");
      if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.start = 1'b1;
      repeat (2) @(negedge clk);
      if16.start = 1'b0;
      repeat (6) @(negedge clk);

      // Back-to-back ops with start held high
      issue16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1, "t4_b2b_first");
      issue16(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 0, "t4_b2b_second");
      repeat (6) @(negedge clk);

      // Async reset in the middle of RUN
      issue16(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 0, "t5_aborted");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_reset_busy", 64'(if16.busy), 64'd0);
      check("midrun_reset_done", 64'(if16.done), 64'd0);
      check("midrun_reset_sum",  64'(if16.sum),  64'd0);
      check("midrun_reset_cout", 64'(if16.cout), 64'd0);
      q16.delete();
      last16 = '0; lastc16 = 1'b0; brun16 = 0;
      last32 = '0; lastc32 = 1'b0; brun32 = 0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (8) @(negedge clk);
      issue16(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 0, "t5_after_reset");
      repeat (6) @(negedge clk);

      // 32-bit random ops, randomly back-to-back
      for (int i = 0; i < 2000; i++) begin
         issue32($urandom, $urandom, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
      if32.start = 1'b0;

      guard = 0;
      while ((q16.size() != 0 || q32.size() != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q16.size(), q32.size());
      end
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
